pipeline_stall_ctrl: RTL

//  Consumer side of the hazard signalling: turns stall/flush requests (load-use hazard from ID,

---
 rtl/pipeline_stall_ctrl_pkg.sv | 15 +
 rtl/pipeline_stall_ctrl_if.sv | 37 +++
 rtl/pipeline_stall_ctrl_sat_counter.sv | 21 ++
 rtl/pipeline_stall_ctrl.sv | 128 ++++++++++++
 4 files changed

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
//   state_e       : FSM encoding (RUN / MEM_WAIT)
//   *_DEF         : default widths and the memory-wait timeout threshold
package pipeline_stall_ctrl_pkg;

   localparam int CNT_W_DEF    = 32;
   localparam int MAX_WAIT_DEF = 16;
   localparam int TO_W_DEF     = 5;

   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } state_e;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard-request / pipeline-control bundle.
//   master : hazard sources (ID/EX/MEM) drive requests, observe controls
//   slave  : stall controller consumes requests, drives enables, flushes
//            and the status counters
interface pipeline_stall_ctrl_if
   import pipeline_stall_ctrl_pkg::*;
   #(parameter int CNT_W = CNT_W_DEF);

   logic             hazard_in;
   logic             branch_taken;
   logic             mem_req;
   logic             mem_ready;
   logic             pc_write;
   logic             if_id_write;
   logic             if_id_flush;
   logic             id_ex_flush;
   logic             ex_mem_write;
   logic             mem_wb_bubble;
   logic             mem_timeout;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] flush_count;

   modport master (
      output hazard_in, branch_taken, mem_req, mem_ready,
      input  pc_write, if_id_write, if_id_flush, id_ex_flush,
             ex_mem_write, mem_wb_bubble, mem_timeout,
             stall_cycles, flush_count
   );

   modport slave (
      input  hazard_in, branch_taken, mem_req, mem_ready,
      output pc_write, if_id_write, if_id_flush, id_ex_flush,
             ex_mem_write, mem_wb_bubble, mem_timeout,
             stall_cycles, flush_count
   );

endinterface

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating event counter.
//   clk, rst : clock, synchronous active-high clear
//   inc      : count this cycle
//   count    : current value, holds at all-ones
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + W'(1);
   end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of pipeline_stall_ctrl_if -- hazard/branch/memory
//              requests in; per-stage enables/flushes, sticky memory
//              timeout and saturating stall/flush counters out
// Controls are combinational so a request acts in the cycle it is raised.
module pipeline_stall_ctrl
   import pipeline_stall_ctrl_pkg::*;
#(
   parameter int CNT_W    = CNT_W_DEF,
   parameter int MAX_WAIT = MAX_WAIT_DEF,
   parameter int TO_W     = TO_W_DEF
) (
   input logic                  clk,
   input logic                  rst,
   pipeline_stall_ctrl_if.slave bus
);

   state_e          state_q, state_d;
   logic            pend_q, pend_d;
   logic [TO_W-1:0] wait_q, wait_d;
   logic            to_q, to_d;
   logic [TO_W-1:0] wait_inc;

   logic pc_w, ifid_w, ifid_f, idex_f, exmem_w, memwb_b;

   assign wait_inc = wait_q + TO_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         pend_q  <= 1'b0;
         wait_q  <= '0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         wait_q  <= wait_d;
         to_q    <= to_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      wait_d  = wait_q;
      to_d    = to_q;
      pc_w    = 1'b1;
      ifid_w  = 1'b1;
      ifid_f  = 1'b0;
      idex_f  = 1'b0;
      exmem_w = 1'b1;
      memwb_b = 1'b0;
      if (rst) begin
         pc_w    = 1'b0;
         ifid_w  = 1'b0;
         exmem_w = 1'b0;
         ifid_f  = 1'b1;
         idex_f  = 1'b1;
         memwb_b = 1'b1;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (bus.mem_req && !bus.mem_ready) begin
                  pc_w    = 1'b0;
                  ifid_w  = 1'b0;
                  exmem_w = 1'b0;
                  memwb_b = 1'b1;
                  state_d = ST_MEM_WAIT;
                  wait_d  = '0;
                  // EX is frozen, so the redirect is replayed on release
                  if (bus.branch_taken) pend_d = 1'b1;
               end else if (bus.branch_taken) begin
                  // dependent instruction is squashed, so hazard_in is moot
                  ifid_f = 1'b1;
                  idex_f = 1'b1;
               end else if (bus.hazard_in) begin
                  pc_w   = 1'b0;
                  ifid_w = 1'b0;
                  idex_f = 1'b1;
               end
            end
            ST_MEM_WAIT: begin
               if (!bus.mem_ready) begin
                  pc_w    = 1'b0;
                  ifid_w  = 1'b0;
                  exmem_w = 1'b0;
                  memwb_b = 1'b1;
                  if (wait_q != '1) wait_d = wait_inc;
                  if ((wait_q != '1) && (wait_inc == TO_W'(MAX_WAIT)))
                     to_d = 1'b1;
               end else begin
                  ifid_f  = pend_q;
                  idex_f  = pend_q;
                  pend_d  = 1'b0;
                  wait_d  = '0;
                  state_d = ST_RUN;
               end
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

   assign bus.pc_write      = pc_w;
   assign bus.if_id_write   = ifid_w;
   assign bus.if_id_flush   = ifid_f;
   assign bus.id_ex_flush   = idex_f;
   assign bus.ex_mem_write  = exmem_w;
   assign bus.mem_wb_bubble = memwb_b;
   assign bus.mem_timeout   = to_q;

   // reset cycles are excluded by the counter's own clear
   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (!pc_w),
      .count (bus.stall_cycles)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (ifid_f),
      .count (bus.flush_count)
   );

endmodule
